// File: rtl/uds_pkg.sv
// Shared definitions for the UDS fetch sequencer: sizes, timeout and FSM state encoding.
package uds_pkg;

  localparam int UDS_WORDS         = 8;
  localparam int UDS_ADDR_W        = 3;
  localparam int UDS_WORD_W        = 32;
  localparam int UDS_READY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_STREAM,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/uds_fetch.sv
// One-shot sequencer that reads the Unique Device Secret from the uds core and streams
// it word by word to a valid/ready consumer, holding at most one word in flight.
module uds_fetch
  import uds_pkg::*;
#(
  parameter int NUM_WORDS     = UDS_WORDS,
  parameter int READY_TIMEOUT = UDS_READY_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fw_app_mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  uds_cs,
  output logic [UDS_ADDR_W-1:0] uds_address,
  input  logic [UDS_WORD_W-1:0] uds_read_data,
  input  logic                  uds_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [UDS_WORD_W-1:0] out_data,
  output logic [UDS_ADDR_W-1:0] out_index,
  output logic                  out_last
);

  localparam int CNT_W = $clog2(READY_TIMEOUT + 1);
  localparam logic [UDS_ADDR_W-1:0] LAST_IDX = UDS_ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(READY_TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic [UDS_WORD_W-1:0]   word_reg, word_next;
  logic [UDS_ADDR_W-1:0]   index_reg, index_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic                    fetched_reg, fetched_next;
  logic                    done_reg, done_next;
  logic                    error_reg, error_next;
  logic                    is_last;

  assign is_last = (index_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      word_reg    <= '0;
      index_reg   <= '0;
      count_reg   <= '0;
      fetched_reg <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      index_reg   <= index_next;
      count_reg   <= count_next;
      fetched_reg <= fetched_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    word_next    = word_reg;
    index_next   = index_reg;
    count_next   = count_reg;
    fetched_next = fetched_reg;
    done_next    = done_reg;
    error_next   = error_reg;
    uds_cs       = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (fw_app_mode || fetched_reg) begin
            state_next = ST_ERROR;
            error_next = 1'b1;
          end else begin
            state_next = ST_READ;
            index_next = '0;
            count_next = '0;
          end
        end
      end

      ST_READ: begin
        busy = 1'b1;
        // App mode kills the read before uds_cs can reach the core.
        if (fw_app_mode) begin
          state_next = ST_ERROR;
          error_next = 1'b1;
          word_next  = '0;
        end else begin
          uds_cs = 1'b1;
          if (uds_ready) begin
            word_next  = uds_read_data;
            state_next = ST_STREAM;
          end else if (count_reg == CNT_MAX) begin
            state_next = ST_ERROR;
            error_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        busy = 1'b1;
        if (fw_app_mode) begin
          state_next = ST_ERROR;
          error_next = 1'b1;
          word_next  = '0;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            word_next = '0;
            if (is_last) begin
              fetched_next = 1'b1;
              done_next    = 1'b1;
              state_next   = ST_DONE;
            end else begin
              index_next = index_reg + 1'b1;
              count_next = '0;
              state_next = ST_READ;
            end
          end
        end
      end

      ST_DONE: begin
        if (start) error_next = 1'b1;
      end

      ST_ERROR: begin
        word_next    = '0;
        fetched_next = 1'b1;
        error_next   = 1'b1;
      end

      default: begin
        state_next = ST_ERROR;
        word_next  = '0;
      end
    endcase
  end

  // The secret is only visible on out_data while it is actually being offered.
  assign out_data    = out_valid ? word_reg : '0;
  assign out_index   = index_reg;
  assign out_last    = out_valid & is_last;
  assign uds_address = index_reg;
  assign done        = done_reg;
  assign error       = error_reg;

endmodule
